// File: rtl/axi4_pkg.sv
// AXI4 shared encodings used by DMA-side blocks.
package axi4_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef logic [2:0] axi_size_t;

endpackage

// File: rtl/axi_dma_controller_pkg.sv
// DMA controller shared types: the command payload carried from requesters to the controller.
package axi_dma_controller_pkg;

  // Address/length field width of the command payload; blocks narrower than this cast on the boundary.
  localparam int unsigned DMA_ADDR_WD = 32;

  typedef struct packed {
    logic [DMA_ADDR_WD-1:0] src_addr;
    logic [DMA_ADDR_WD-1:0] dst_addr;
    axi4_pkg::axi_burst_t   burst;
    logic [DMA_ADDR_WD-1:0] len;
    axi4_pkg::axi_size_t    size;
  } dma_cmd_t;

endpackage

// File: rtl/axi_dma_rr_arb.sv
// Combinational round-robin select: first eligible index at or after rr_ptr, searching upward modulo N.
module axi_dma_rr_arb #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 grant_valid
);

  localparam int unsigned IDX_WD = $clog2(N);

  logic [IDX_WD-1:0] idx_c [N];

  // Candidate index for each search offset, wrapped modulo N.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      idx_c[k] = IDX_WD'((32'(rr_ptr) + k) % N);
    end
  end

  // Take the first eligible candidate in search order.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_valid && eligible[idx_c[k]]) begin
        grant       = idx_c[k];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_dma_cmd_arbiter.sv
// Round-robin arbiter feeding a single-slot command register toward the AXI DMA controller.
module axi_dma_cmd_arbiter
  import axi_dma_controller_pkg::*;
#(
  parameter int unsigned ADDR_WD       = 32,
  parameter int unsigned CHANNEL_COUNT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNEL_COUNT-1:0]         req_valid,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] req_src_addr,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] req_dst_addr,
  input  logic [CHANNEL_COUNT*2-1:0]       req_burst,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] req_len,
  input  logic [CHANNEL_COUNT*3-1:0]       req_size,
  output logic [CHANNEL_COUNT-1:0]         req_ready,
  input  logic [CHANNEL_COUNT-1:0]         chan_en,
  output logic                             cmd_valid,
  output logic [ADDR_WD-1:0]               cmd_src_addr,
  output logic [ADDR_WD-1:0]               cmd_dst_addr,
  output logic [1:0]                       cmd_burst,
  output logic [ADDR_WD-1:0]               cmd_len,
  output logic [2:0]                       cmd_size,
  input  logic                             cmd_ready,
  output logic [$clog2(CHANNEL_COUNT)-1:0] cmd_chan_id,
  output logic                             zero_len_drop,
  output logic [15:0]                      cmd_issued_cnt
);

  localparam int unsigned N      = CHANNEL_COUNT;
  localparam int unsigned IDX_WD = $clog2(CHANNEL_COUNT);

  logic [N-1:0]      eligible_c;
  logic [IDX_WD-1:0] grant_c;
  logic              grant_valid_c;
  logic              load_en_c;
  logic              hs_c;
  logic              zero_len_c;
  dma_cmd_t          sel_c;

  logic              cmd_valid_q, cmd_valid_d;
  dma_cmd_t          cmd_q, cmd_d;
  logic [IDX_WD-1:0] chan_id_q, chan_id_d;
  logic [IDX_WD-1:0] rr_ptr_q, rr_ptr_d;
  logic              zero_len_drop_q, zero_len_drop_d;
  logic [15:0]       cmd_issued_cnt_q, cmd_issued_cnt_d;

  assign eligible_c = req_valid & chan_en;
  assign load_en_c  = !cmd_valid_q || cmd_ready;

  axi_dma_rr_arb #(
    .N (N)
  ) u_rr_arb (
    .eligible    (eligible_c),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant_c),
    .grant_valid (grant_valid_c)
  );

  // Mux the granted requester's command fields into one payload.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c == IDX_WD'(i)) begin
        sel_c.src_addr = DMA_ADDR_WD'(req_src_addr[i*ADDR_WD +: ADDR_WD]);
        sel_c.dst_addr = DMA_ADDR_WD'(req_dst_addr[i*ADDR_WD +: ADDR_WD]);
        sel_c.len      = DMA_ADDR_WD'(req_len[i*ADDR_WD +: ADDR_WD]);
        sel_c.burst    = axi4_pkg::axi_burst_t'(req_burst[i*2 +: 2]);
        sel_c.size     = req_size[i*3 +: 3];
      end
    end
  end

  // One-hot accept toward the granted requester while the slot can take a command.
  always_comb begin
    req_ready = '0;
    if (!rst && load_en_c && grant_valid_c) begin
      req_ready[grant_c] = 1'b1;
    end
  end

  assign hs_c       = |req_ready;
  assign zero_len_c = (sel_c.len == '0);

  // Slot, pointer, drop pulse and issue counter next-state.
  always_comb begin
    cmd_valid_d      = cmd_valid_q;
    cmd_d            = cmd_q;
    chan_id_d        = chan_id_q;
    rr_ptr_d         = rr_ptr_q;
    zero_len_drop_d  = 1'b0;
    cmd_issued_cnt_d = cmd_issued_cnt_q;
    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d      = 1'b0;
      cmd_issued_cnt_d = cmd_issued_cnt_q + 16'd1;
    end
    if (hs_c) begin
      rr_ptr_d = (grant_c == IDX_WD'(N - 1)) ? '0 : grant_c + IDX_WD'(1);
      if (zero_len_c) begin
        // Zero-length commands are consumed but never reach the controller.
        zero_len_drop_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_d       = sel_c;
        chan_id_d   = grant_c;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q      <= 1'b0;
      cmd_q            <= '0;
      chan_id_q        <= '0;
      rr_ptr_q         <= '0;
      zero_len_drop_q  <= 1'b0;
      cmd_issued_cnt_q <= '0;
    end else begin
      cmd_valid_q      <= cmd_valid_d;
      cmd_q            <= cmd_d;
      chan_id_q        <= chan_id_d;
      rr_ptr_q         <= rr_ptr_d;
      zero_len_drop_q  <= zero_len_drop_d;
      cmd_issued_cnt_q <= cmd_issued_cnt_d;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_src_addr   = ADDR_WD'(cmd_q.src_addr);
  assign cmd_dst_addr   = ADDR_WD'(cmd_q.dst_addr);
  assign cmd_len        = ADDR_WD'(cmd_q.len);
  assign cmd_burst      = cmd_q.burst;
  assign cmd_size       = cmd_q.size;
  assign cmd_chan_id    = chan_id_q;
  assign zero_len_drop  = zero_len_drop_q;
  assign cmd_issued_cnt = cmd_issued_cnt_q;

endmodule

// File: tb/tb_axi_dma_cmd_arbiter.sv
// Self-checking bench for axi_dma_cmd_arbiter against a transaction-level reference model.
module tb_axi_dma_cmd_arbiter;

  localparam int N  = 8;
  localparam int AW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_src_addr, req_dst_addr, req_len;
  logic [N*2-1:0]  req_burst;
  logic [N*3-1:0]  req_size;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    chan_en;
  logic            cmd_valid;
  logic [AW-1:0]   cmd_src_addr, cmd_dst_addr, cmd_len;
  logic [1:0]      cmd_burst;
  logic [2:0]      cmd_size;
  logic            cmd_ready;
  logic [2:0]      cmd_chan_id;
  logic            zero_len_drop;
  logic [15:0]     cmd_issued_cnt;

  logic [AW-1:0] t_src [N];
  logic [AW-1:0] t_dst [N];
  logic [AW-1:0] t_len [N];
  logic [1:0]    t_burst [N];
  logic [2:0]    t_size [N];

  int checks   = 0;
  int failures = 0;

  // Reference model: a one-entry queue of commands plus a round-robin pointer.
  bit          m_valid;
  logic [AW-1:0] m_src, m_dst, m_len;
  logic [1:0]  m_burst;
  logic [2:0]  m_size;
  int          m_chan;
  int          m_ptr;
  bit          m_drop;
  int          m_cnt;
  int          m_issued_total;

  axi_dma_cmd_arbiter #(.ADDR_WD(AW), .CHANNEL_COUNT(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_src_addr   (req_src_addr),
    .req_dst_addr   (req_dst_addr),
    .req_burst      (req_burst),
    .req_len        (req_len),
    .req_size       (req_size),
    .req_ready      (req_ready),
    .chan_en        (chan_en),
    .cmd_valid      (cmd_valid),
    .cmd_src_addr   (cmd_src_addr),
    .cmd_dst_addr   (cmd_dst_addr),
    .cmd_burst      (cmd_burst),
    .cmd_len        (cmd_len),
    .cmd_size       (cmd_size),
    .cmd_ready      (cmd_ready),
    .cmd_chan_id    (cmd_chan_id),
    .zero_len_drop  (zero_len_drop),
    .cmd_issued_cnt (cmd_issued_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_src_addr = '0;
    req_dst_addr = '0;
    req_len      = '0;
    req_burst    = '0;
    req_size     = '0;
    for (int i = 0; i < N; i++) begin
      req_src_addr[i*AW +: AW] = t_src[i];
      req_dst_addr[i*AW +: AW] = t_dst[i];
      req_len[i*AW +: AW]      = t_len[i];
      req_burst[i*2 +: 2]      = t_burst[i];
      req_size[i*3 +: 3]       = t_size[i];
    end
  end

  function automatic void report(input string name, input longint act, input longint exp);
    failures++;
    if (failures <= 40)
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endfunction

  function automatic int model_grant(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i, input bit allow_zero);
    t_src[i]   = $urandom;
    t_dst[i]   = $urandom;
    t_len[i]   = (allow_zero && $urandom_range(0, 3) == 0) ? '0 : ($urandom | 32'h1);
    t_burst[i] = 2'($urandom);
    t_size[i]  = 3'($urandom);
  endtask

  // One clock: check accepts before the edge, advance the model, check registered outputs after.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    if (rst || (m_valid && !cmd_ready)) g = -1;
    else g = model_grant(req_valid & chan_en, m_ptr);
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    checks++;
    if (req_ready !== exp_rdy) report("req_ready", longint'(req_ready), longint'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_src = '0; m_dst = '0; m_len = '0; m_burst = '0; m_size = '0;
      m_chan = 0; m_ptr = 0; m_drop = 0; m_cnt = 0;
    end else begin
      if (m_valid && cmd_ready) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_issued_total++;
        m_valid = 0;
      end
      m_drop = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (t_len[g] == '0) m_drop = 1;
        else begin
          m_valid = 1; m_chan = g;
          m_src = t_src[g]; m_dst = t_dst[g]; m_len = t_len[g];
          m_burst = t_burst[g]; m_size = t_size[g];
        end
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== m_valid) report("cmd_valid", longint'(cmd_valid), longint'(m_valid));
    checks++;
    if (zero_len_drop !== m_drop) report("zero_len_drop", longint'(zero_len_drop), longint'(m_drop));
    checks++;
    if (cmd_issued_cnt !== 16'(m_cnt)) report("cmd_issued_cnt", longint'(cmd_issued_cnt), longint'(m_cnt));
    if (m_valid) begin
      checks++;
      if ({cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, cmd_chan_id} !==
          {m_src, m_dst, m_len, m_burst, m_size, 3'(m_chan)})
        report("cmd_fields", longint'({cmd_chan_id, cmd_src_addr}), longint'({3'(m_chan), m_src}));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1; chan_en = '1; cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i, 0);
    do_reset();
    checks++;
    if ({cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, cmd_chan_id,
         zero_len_drop, cmd_issued_cnt} !== '0)
      report("reset_outputs", longint'({cmd_valid, cmd_chan_id, cmd_issued_cnt}), 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = '1; chan_en = '1; cmd_ready = 1'b1;
    for (int k = 0; k < N + 1; k++) begin
      step();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_chan_id !== 3'(k % N))
        report("rr_sequence", longint'({cmd_valid, cmd_chan_id}), longint'({1'b1, 3'(k % N)}));
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] first_src;
    do_reset();
    req_valid = 8'h08; chan_en = '1; cmd_ready = 1'b0;
    rand_req(3, 0);
    step();
    first_src = t_src[3];
    rand_req(3, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_src_addr !== first_src || req_ready[3] !== 1'b0)
        report("backpressure_hold", longint'(cmd_src_addr), longint'(first_src));
    end
    cmd_ready = 1'b1;
    step();
    checks++;
    if (cmd_issued_cnt !== 16'd1) report("backpressure_release", longint'(cmd_issued_cnt), 1);
  endtask

  task automatic test_zero_len();
    do_reset();
    req_valid = 8'h04; chan_en = '1; cmd_ready = 1'b1;
    rand_req(2, 0);
    t_len[2] = '0;
    step();
    checks++;
    if (zero_len_drop !== 1'b1 || cmd_valid !== 1'b0)
      report("zero_len_drop", longint'({zero_len_drop, cmd_valid}), 2);
    req_valid = '0;
    step();
    req_valid = '1;
    for (int i = 0; i < N; i++) rand_req(i, 0);
    #1;
    checks++;
    if (req_ready !== 8'h08) report("zero_len_ptr", longint'(req_ready), 8);
    step();
  endtask

  task automatic test_chan_en();
    do_reset();
    req_valid = '1; chan_en = 8'h01; cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== 8'h01) report("chan_en_only0", longint'(req_ready), 1);
      step();
    end
    chan_en = 8'hFF;
    #1;
    checks++;
    if (req_ready !== 8'h02) report("chan_en_resume", longint'(req_ready), 2);
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 8'h30; chan_en = '1; cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i, 0);
    step();
    step();
    cmd_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_issued_cnt !== 16'd0)
      report("reset_mid", longint'({cmd_valid, cmd_issued_cnt}), 0);
    rst = 1'b0;
    req_valid = '1; cmd_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h01) report("reset_first_grant", longint'(req_ready), 1);
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      chan_en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      cmd_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) rand_req(i, 1);
      step();
    end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    req_valid = '1; chan_en = '1; cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i, 0);
    m_issued_total = 0;
    c = 0;
    while (m_issued_total < 65536 && c < 70000) begin
      step();
      c++;
    end
    checks++;
    if (m_issued_total != 65536) report("wrap_timeout", longint'(m_issued_total), 65536);
    checks++;
    if (cmd_issued_cnt !== 16'h0000) report("cnt_wrap", longint'(cmd_issued_cnt), 0);
    checks++;
    if (c != 65537) report("throughput_cycles", longint'(c), 65537);
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; chan_en = '0; cmd_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_src[i] = '0; t_dst[i] = '0; t_len[i] = '0; t_burst[i] = '0; t_size[i] = '0;
    end
    m_valid = 0; m_src = '0; m_dst = '0; m_len = '0; m_burst = '0; m_size = '0;
    m_chan = 0; m_ptr = 0; m_drop = 0; m_cnt = 0; m_issued_total = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_chan_en();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
